// File: rtl/demo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : demo_sequencer
// Purpose  : Frame-level scene scheduler. Counts frames from the VGA vertical
//            sync, fades each scene in and out, exposes a per-scene frame
//            counter for animation and pulses scene_start_o so the graphics
//            and audio engines can reload per-scene state.
// Ports    : clk            - system/pixel clock
//            rst_n          - asynchronous reset, active low
//            v_sync_i       - raw vertical sync, active low (fall = frame tick)
//            pause_i        - level; 1 ignores frame ticks (skip still works)
//            skip_i         - asynchronous button; rising edge ends scene early
//            scene_o        - current scene index
//            brightness_o   - fade level, 0 = black, 7 = full
//            scene_frame_o  - accepted ticks since scene start, saturating
//            scene_start_o  - one-cycle pulse as a scene begins fading in
//            fading_o       - high while fading in or out
// Options  : DEMO_SEQ_LOOP_EN - when defined, the last scene fades out and the
//            demo wraps to scene 0; otherwise the last scene's SHOW is terminal.
// Revision : 1.0 - initial release
// ============================================================================
module demo_sequencer #(
    parameter int NUM_SCENES   = 4,
    parameter int SCENE_FRAMES = 240,
    parameter int FADE_STEP    = 4,
    parameter int FRAME_W      = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               v_sync_i,
    input  logic               pause_i,
    input  logic               skip_i,
    output logic [1:0]         scene_o,
    output logic [2:0]         brightness_o,
    output logic [FRAME_W-1:0] scene_frame_o,
    output logic               scene_start_o,
    output logic               fading_o
);

`ifdef DEMO_SEQ_LOOP_EN
    localparam bit C_LOOP_EN = 1'b1;
`else
    localparam bit C_LOOP_EN = 1'b0;
`endif

    localparam logic [1:0]         C_LAST_SCENE = 2'(NUM_SCENES - 1);
    localparam logic [FRAME_W-1:0] C_SHOW_LAST  = FRAME_W'(SCENE_FRAMES - 1);
    localparam logic [FRAME_W-1:0] C_FRAME_MAX  = '1;
    localparam logic [3:0]         C_FADE_LAST  = 4'(FADE_STEP - 1);

    typedef enum logic [2:0] {
        ST_START    = 3'd0,
        ST_FADE_IN  = 3'd1,
        ST_SHOW     = 3'd2,
        ST_FADE_OUT = 3'd3,
        ST_SWITCH   = 3'd4
    } state_t;

    state_t             state_q,       state_d;
    logic [1:0]         scene_q,       scene_d;
    logic [2:0]         brightness_q,  brightness_d;
    logic [FRAME_W-1:0] scene_frame_q, scene_frame_d;
    logic [3:0]         fade_div_q,    fade_div_d;
    logic               scene_start_q, scene_start_d;

    logic v_sync_q;
    logic skip_meta_q;
    logic skip_sync_q;
    logic skip_prev_q;

    logic tick;
    logic tick_acc;
    logic skip_edge;
    logic fade_step;
    logic show_terminal;

    // Frame tick on the falling edge of the (already synchronous) sync pulse.
    assign tick      = v_sync_q & ~v_sync_i;
    assign tick_acc  = tick & ~pause_i;
    // Two-flop synchroniser then edge detect: one pulse per press, even if held.
    assign skip_edge = skip_sync_q & ~skip_prev_q;
    assign fade_step = (fade_div_q == C_FADE_LAST);
    // Without looping, the last scene stays lit forever once it reaches SHOW.
    assign show_terminal = !C_LOOP_EN && (scene_q == C_LAST_SCENE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sync_q      <= 1'b0;
            skip_meta_q   <= 1'b0;
            skip_sync_q   <= 1'b0;
            skip_prev_q   <= 1'b0;
            state_q       <= ST_START;
            scene_q       <= 2'd0;
            brightness_q  <= 3'd0;
            scene_frame_q <= '0;
            fade_div_q    <= 4'd0;
            scene_start_q <= 1'b0;
        end else begin
            v_sync_q      <= v_sync_i;
            skip_meta_q   <= skip_i;
            skip_sync_q   <= skip_meta_q;
            skip_prev_q   <= skip_sync_q;
            state_q       <= state_d;
            scene_q       <= scene_d;
            brightness_q  <= brightness_d;
            scene_frame_q <= scene_frame_d;
            fade_div_q    <= fade_div_d;
            scene_start_q <= scene_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        scene_d       = scene_q;
        brightness_d  = brightness_q;
        scene_frame_d = scene_frame_q;
        fade_div_d    = fade_div_q;
        scene_start_d = 1'b0;

        // Frame counter runs in every visible state, independent of transitions.
        if (tick_acc && (state_q == ST_FADE_IN || state_q == ST_SHOW ||
                         state_q == ST_FADE_OUT)) begin
            if (scene_frame_q != C_FRAME_MAX) begin
                scene_frame_d = scene_frame_q + 1'b1;
            end
        end

        case (state_q)
            ST_START: begin
                if (tick_acc) begin
                    state_d       = ST_FADE_IN;
                    scene_start_d = 1'b1;
                end
            end

            ST_FADE_IN: begin
                if (skip_edge) begin
                    // Abort the fade-in at whatever level has been reached.
                    state_d = ST_FADE_OUT;
                end else if (tick_acc) begin
                    if (fade_step) begin
                        fade_div_d = 4'd0;
                        if (brightness_q >= 3'd6) begin
                            brightness_d = 3'd7;
                            state_d      = ST_SHOW;
                        end else begin
                            brightness_d = brightness_q + 3'd1;
                        end
                    end else begin
                        fade_div_d = fade_div_q + 4'd1;
                    end
                end
            end

            ST_SHOW: begin
                if (!show_terminal) begin
                    if (skip_edge ||
                        (tick_acc && scene_frame_q >= C_SHOW_LAST)) begin
                        state_d = ST_FADE_OUT;
                    end
                end
            end

            ST_FADE_OUT: begin
                if (tick_acc) begin
                    if (fade_step) begin
                        fade_div_d = 4'd0;
                        // Also covers entering already black after an early skip.
                        if (brightness_q <= 3'd1) begin
                            brightness_d = 3'd0;
                            state_d      = ST_SWITCH;
                        end else begin
                            brightness_d = brightness_q - 3'd1;
                        end
                    end else begin
                        fade_div_d = fade_div_q + 4'd1;
                    end
                end
            end

            ST_SWITCH: begin
                state_d       = ST_FADE_IN;
                scene_frame_d = '0;
                scene_start_d = 1'b1;
                if (scene_q == C_LAST_SCENE) begin
                    scene_d = C_LOOP_EN ? 2'd0 : scene_q;
                end else begin
                    scene_d = scene_q + 2'd1;
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase

        // Each state starts with a fresh fade divider.
        if (state_d != state_q) begin
            fade_div_d = 4'd0;
        end
    end

    assign scene_o       = scene_q;
    assign brightness_o  = brightness_q;
    assign scene_frame_o = scene_frame_q;
    assign scene_start_o = scene_start_q;
    assign fading_o      = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT);

endmodule
`default_nettype wire

// File: tb/tb_demo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_demo_sequencer
// Purpose  : Self-checking bench for demo_sequencer (SCENE_FRAMES=10,
//            FADE_STEP=1, NUM_SCENES=4). Expected per-tick outputs are queued
//            as stimulus is planned and popped after each frame tick.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demo_sequencer;

    localparam int NUM_SCENES   = 4;
    localparam int SCENE_FRAMES = 10;
    localparam int FADE_STEP    = 1;
    localparam int FRAME_W      = 10;
    localparam int GAP          = 19;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               v_sync_i = 1'b1;
    logic               pause_i  = 1'b0;
    logic               skip_i   = 1'b0;
    logic [1:0]         scene_o;
    logic [2:0]         brightness_o;
    logic [FRAME_W-1:0] scene_frame_o;
    logic               scene_start_o;
    logic               fading_o;

    demo_sequencer #(
        .NUM_SCENES  (NUM_SCENES),
        .SCENE_FRAMES(SCENE_FRAMES),
        .FADE_STEP   (FADE_STEP),
        .FRAME_W     (FRAME_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .v_sync_i     (v_sync_i),
        .pause_i      (pause_i),
        .skip_i       (skip_i),
        .scene_o      (scene_o),
        .brightness_o (brightness_o),
        .scene_frame_o(scene_frame_o),
        .scene_start_o(scene_start_o),
        .fading_o     (fading_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]         scene;
        logic [2:0]         bright;
        logic [FRAME_W-1:0] frame;
        logic               fading;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   start_cnt = 0;

    always @(posedge clk) begin
        if (scene_start_o === 1'b1) start_cnt++;
    end

    function automatic obs_t mk(input int s, input int b, input int f, input bit fd);
        obs_t o;
        o.scene  = 2'(s);
        o.bright = 3'(b);
        o.frame  = FRAME_W'(f);
        o.fading = fd;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.scene  = scene_o;
        o.bright = brightness_o;
        o.frame  = scene_frame_o;
        o.fading = fading_o;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("scene=%0d bright=%0d frame=%0d fading=%0b",
                         o.scene, o.bright, o.frame, o.fading);
    endfunction

    // One v_sync fall; returns at the falling clock edge just after the tick.
    task automatic vsync_tick(input int gap);
        repeat (gap) @(negedge clk);
        v_sync_i = 1'b0;
        @(negedge clk);
        v_sync_i = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({scene_o, brightness_o, scene_frame_o, scene_start_o, fading_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got %s start=%0b, want all zero",
                     fmt(observe()), scene_start_o);
        end
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_tests++;
        if (fading_o !== 1'b0 || start_cnt != 0) begin
            n_fail++;
            $display("FAIL idle_no_tick: got fading=%0b starts=%0d, want 0/0",
                     fading_o, start_cnt);
        end
    endtask

    task automatic test_fade_in;
        obs_t got, want;
        exp_q.push_back(mk(0, 0, 0, 1'b1));
        for (int i = 1; i <= 7; i++) exp_q.push_back(mk(0, i, i, i != 7));
        for (int i = 0; i <= 7; i++) begin
            vsync_tick(GAP);
            if (i == 0) begin
                n_tests++;
                if (scene_start_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL first_start: got scene_start=%0b, want 1", scene_start_o);
                end
            end
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL fade_in[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
        n_tests++;
        if (start_cnt != 1) begin
            n_fail++;
            $display("FAIL start_count: got %0d pulses, want 1", start_cnt);
        end
    endtask

    task automatic test_show_fade_out;
        obs_t got, want;
        int   cnt0;
        exp_q.push_back(mk(0, 7, 8, 1'b0));
        exp_q.push_back(mk(0, 7, 9, 1'b0));
        exp_q.push_back(mk(0, 7, 10, 1'b1));
        for (int i = 1; i <= 7; i++) exp_q.push_back(mk(0, 7 - i, 10 + i, i != 7));
        for (int i = 0; i < 10; i++) begin
            vsync_tick(GAP);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL show_fade_out[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
        cnt0 = start_cnt;
        @(negedge clk);
        got = observe();
        n_tests++;
        if (got !== mk(1, 0, 0, 1'b1) || scene_start_o !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_to_1: got %s start=%0b, want %s start=1",
                     fmt(got), scene_start_o, fmt(mk(1, 0, 0, 1'b1)));
        end
        @(negedge clk);
        n_tests++;
        if (scene_start_o !== 1'b0 || start_cnt != cnt0 + 1) begin
            n_fail++;
            $display("FAIL single_start: got start=%0b pulses=%0d, want 0/%0d",
                     scene_start_o, start_cnt - cnt0, 1);
        end
    endtask

    // Skip while still black in FADE_IN; held well past 100 cycles.
    task automatic test_skip_at_black;
        obs_t got, want;
        skip_i = 1'b1;
        exp_q.push_back(mk(1, 0, 1, 1'b0));
        vsync_tick(GAP);
        got  = observe();
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL skip_black_switch: got %s, want %s", fmt(got), fmt(want));
        end
        @(negedge clk);
        got = observe();
        n_tests++;
        if (got !== mk(2, 0, 0, 1'b1) || scene_start_o !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_to_2: got %s start=%0b, want %s start=1",
                     fmt(got), scene_start_o, fmt(mk(2, 0, 0, 1'b1)));
        end
        for (int i = 1; i <= 7; i++) exp_q.push_back(mk(2, i, i, i != 7));
        for (int i = 1; i <= 7; i++) begin
            vsync_tick(GAP);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL held_skip_fade_in[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
            if (i == 3) begin
                repeat (25) @(negedge clk);
                skip_i = 1'b0;
            end
        end
    endtask

    task automatic test_pause;
        obs_t got, want;
        pause_i = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(mk(2, 7, 7, 1'b0));
        for (int i = 0; i < 10; i++) begin
            vsync_tick(GAP);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want || scene_start_o !== 1'b0) begin
                n_fail++;
                $display("FAIL pause[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
        pause_i = 1'b0;
        exp_q.push_back(mk(2, 7, 8, 1'b0));
        vsync_tick(GAP);
        got  = observe();
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL pause_resume: got %s, want %s", fmt(got), fmt(want));
        end
    endtask

    task automatic test_skip_show;
        obs_t got, want;
        @(negedge clk);
        skip_i = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (fading_o !== 1'b0) begin
            n_fail++;
            $display("FAIL skip_too_early: got fading=%0b 2 cycles after press, want 0", fading_o);
        end
        @(negedge clk);
        got = observe();
        n_tests++;
        if (got !== mk(2, 7, 8, 1'b1)) begin
            n_fail++;
            $display("FAIL skip_show: got %s, want %s", fmt(got), fmt(mk(2, 7, 8, 1'b1)));
        end
        repeat (5) @(negedge clk);
        skip_i = 1'b0;
        for (int i = 1; i <= 7; i++) exp_q.push_back(mk(2, 7 - i, 8 + i, i != 7));
        for (int i = 1; i <= 7; i++) exp_q.push_back(mk(3, i, i, i != 7));
        for (int i = 0; i < 14; i++) begin
            vsync_tick(GAP);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL skip_fade_out_next[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
            if (i == 6) begin
                @(negedge clk);
                n_tests++;
                if (scene_o !== 2'd3 || scene_start_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL switch_to_3: got scene=%0d start=%0b, want 3/1",
                             scene_o, scene_start_o);
                end
            end
        end
    endtask

    task automatic test_last_scene;
        obs_t got, want;
`ifdef DEMO_SEQ_LOOP_EN
        exp_q.push_back(mk(3, 7, 8, 1'b0));
        exp_q.push_back(mk(3, 7, 9, 1'b0));
        exp_q.push_back(mk(3, 7, 10, 1'b1));
        for (int i = 1; i <= 7; i++) exp_q.push_back(mk(3, 7 - i, 10 + i, i != 7));
        for (int i = 0; i < 10; i++) begin
            vsync_tick(GAP);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL loop_fade_out[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
        @(negedge clk);
        got = observe();
        n_tests++;
        if (got !== mk(0, 0, 0, 1'b1) || scene_start_o !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_wrap: got %s start=%0b, want %s start=1",
                     fmt(got), scene_start_o, fmt(mk(0, 0, 0, 1'b1)));
        end
`else
        @(negedge clk);
        skip_i = 1'b1;
        repeat (10) @(negedge clk);
        skip_i = 1'b0;
        repeat (5) @(negedge clk);
        got = observe();
        n_tests++;
        if (got !== mk(3, 7, 7, 1'b0)) begin
            n_fail++;
            $display("FAIL terminal_skip: got %s, want %s", fmt(got), fmt(mk(3, 7, 7, 1'b0)));
        end
        for (int i = 1; i <= 20; i++) exp_q.push_back(mk(3, 7, 7 + i, 1'b0));
        for (int i = 1; i <= 1000; i++)
            exp_q.push_back(mk(3, 7, (27 + i > 1023) ? 1023 : 27 + i, 1'b0));
        for (int i = 0; i < 1020; i++) begin
            vsync_tick((i < 20) ? GAP : 1);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL terminal_show[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
`endif
    endtask

    task automatic test_reset_mid_fade;
        obs_t got, want;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 1'b1));
        for (int i = 1; i <= 7; i++) exp_q.push_back(mk(0, i, i, i != 7));
        exp_q.push_back(mk(0, 7, 8, 1'b0));
        exp_q.push_back(mk(0, 7, 9, 1'b0));
        exp_q.push_back(mk(0, 7, 10, 1'b1));
        for (int i = 1; i <= 4; i++) exp_q.push_back(mk(0, 7 - i, 10 + i, 1'b1));
        for (int i = 0; i < 15; i++) begin
            vsync_tick(GAP);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL rerun[%0d]: got %s, want %s", i, fmt(got), fmt(want));
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({scene_o, brightness_o, scene_frame_o, scene_start_o, fading_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %s start=%0b, want all zero",
                     fmt(observe()), scene_start_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_tests++;
        if (fading_o !== 1'b0 || brightness_o !== 3'd0 || scene_start_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_for_vsync: got %s start=%0b, want idle START",
                     fmt(observe()), scene_start_o);
        end
        exp_q.push_back(mk(0, 0, 0, 1'b1));
        vsync_tick(GAP);
        got  = observe();
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want || scene_start_o !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got %s start=%0b, want %s start=1",
                     fmt(got), scene_start_o, fmt(want));
        end
    endtask

    initial begin
        test_reset();
        test_fade_in();
        test_show_fade_out();
        test_skip_at_black();
        test_pause();
        test_skip_show();
        test_last_scene();
        test_reset_mid_fade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
